// File: rtl/tx_buf_pkg.sv
// Shared types and defaults for the TX data buffer: launch FSM state encoding
// and the default FIFO geometry.
package tx_buf_pkg;

    localparam int DEPTH_DEFAULT = 8;
    localparam int DW_DEFAULT    = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/tx_buf_fifo.sv
// Circular FIFO behind the TX launch logic: storage, wrapping pointers and
// occupancy flags derived from the registered count.
module tx_buf_fifo
    import tx_buf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int DW    = DW_DEFAULT,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; its contents are only read once
    // count says they were written, so resetting it would buy nothing.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tx_data_buffer.sv
// Host-to-TX byte buffer: FIFO plus a launch FSM handshaking on TX_BUSY.
// Optional sticky overflow flag enabled by defining TX_BUF_OVF_EN.
module tx_data_buffer
    import tx_buf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [DW-1:0]                WR_DATA,
    input  logic                         WR_EN,
    input  logic                         TX_BUSY,
    output logic [DW-1:0]                P_DATA,
    output logic                         DATA_VALID,
    output logic                         FULL,
    output logic                         EMPTY,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT,
    output logic                         OVF,
    input  logic                         OVF_CLR
);

    localparam int CW = $clog2(DEPTH + 1);

    tx_state_e     state;
    logic          launch;
    logic [DW-1:0] head;

    // A launch pops the head in the same edge it is copied to P_DATA.
    assign launch = (state == IDLE) && !EMPTY;

    tx_buf_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .CW    (CW)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (WR_EN),
        .wr_data (WR_DATA),
        .rd_en   (launch),
        .rd_data (head),
        .count   (COUNT),
        .full    (FULL),
        .empty   (EMPTY)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        P_DATA     <= head;
                        DATA_VALID <= 1'b1;
                        state      <= WAIT_BUSY;
                    end else begin
                        DATA_VALID <= 1'b0;
                    end
                end
                WAIT_BUSY: begin
                    DATA_VALID <= 1'b0;
                    if (TX_BUSY) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    DATA_VALID <= 1'b0;
                    if (!TX_BUSY) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    DATA_VALID <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef TX_BUF_OVF_EN
    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            OVF <= 1'b0;
        end else if (WR_EN && FULL) begin
            OVF <= 1'b1;
        end else if (OVF_CLR) begin
            OVF <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = OVF_CLR;
    assign OVF            = 1'b0;
`endif

endmodule

// File: tb/tb_tx_data_buffer.sv
// Randomized self-checking bench for tx_data_buffer against a queue-based
// model of the buffer and its launch handshake.
module tb_tx_data_buffer;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef TX_BUF_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] WR_DATA;
    logic          WR_EN;
    logic          TX_BUSY;
    logic          OVF_CLR;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          FULL;
    logic          EMPTY;
    logic [CW-1:0] COUNT;
    logic          OVF;

    tx_data_buffer #(.DEPTH(DEPTH), .DW(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .WR_DATA    (WR_DATA),
        .WR_EN      (WR_EN),
        .TX_BUSY    (TX_BUSY),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .FULL       (FULL),
        .EMPTY      (EMPTY),
        .COUNT      (COUNT),
        .OVF        (OVF),
        .OVF_CLR    (OVF_CLR)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queued bytes, the byte on the TX side and whether a frame
    // is still outstanding (launched, busy not yet seen rising and falling).
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_pdata;
    bit            m_dv;
    bit            m_launched;
    bit            m_busy_seen;
    bit            m_ovf;

    // TX controller emulation.
    bit tx_manual;
    bit tx_manual_val;
    bit tx_rand;
    int tx_rise;
    int tx_len;
    int pre_cnt;
    int busy_cnt;

    logic [DW-1:0] out_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pdata     = '0;
        m_dv        = 1'b0;
        m_launched  = 1'b0;
        m_busy_seen = 1'b0;
        m_ovf       = 1'b0;
        pre_cnt     = 0;
        busy_cnt    = 0;
    endtask

    task automatic model_edge();
        bit empty_pre;
        bit full_pre;
        empty_pre = (q.size() == 0);
        full_pre  = (q.size() == DEPTH);
        if (!m_launched && !empty_pre) begin
            m_pdata     = q.pop_front();
            m_dv        = 1'b1;
            m_launched  = 1'b1;
            m_busy_seen = 1'b0;
        end else begin
            m_dv = 1'b0;
            if (m_launched) begin
                if (!m_busy_seen) begin
                    if (TX_BUSY) m_busy_seen = 1'b1;
                end else if (!TX_BUSY) begin
                    m_launched = 1'b0;
                end
            end
        end
        if (WR_EN && !full_pre) q.push_back(WR_DATA);
        if (OVF_EN) begin
            if (WR_EN && full_pre) m_ovf = 1'b1;
            else if (OVF_CLR)      m_ovf = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("count", 32'(COUNT), 32'(q.size()));
        check("empty", 32'(EMPTY), 32'(q.size() == 0));
        check("full", 32'(FULL), 32'(q.size() == DEPTH));
        check("data_valid", 32'(DATA_VALID), 32'(m_dv));
        check("p_data", 32'(P_DATA), 32'(m_pdata));
        check("ovf", 32'(OVF), 32'(m_ovf));
    endtask

    task automatic tx_drive();
        if (tx_manual) begin
            TX_BUSY = tx_manual_val;
        end else if (busy_cnt > 0) begin
            TX_BUSY = 1'b1;
            busy_cnt--;
        end else begin
            TX_BUSY = 1'b0;
            if (m_dv) begin
                if (tx_rand) begin
                    tx_rise = $urandom_range(1, 3);
                    tx_len  = $urandom_range(1, 12);
                end
                pre_cnt = tx_rise;
            end else if (pre_cnt > 0) begin
                pre_cnt--;
                if (pre_cnt == 0) busy_cnt = tx_len;
            end
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic cycle(input bit we, input logic [DW-1:0] d, input bit clr);
        tx_drive();
        WR_EN   = we;
        WR_DATA = d;
        OVF_CLR = clr;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        compare_all();
        if (DATA_VALID === 1'b1) out_log.push_back(P_DATA);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        RST = 1'b1; WR_EN = 1'b0; WR_DATA = '0; TX_BUSY = 1'b0; OVF_CLR = 1'b0;
        tx_manual = 1'b0; tx_manual_val = 1'b0; tx_rand = 1'b0; tx_rise = 2; tx_len = 11;
        model_reset();

        // Asynchronous reset with no clock edge.
        #3 RST = 1'b0;
        #1;
        compare_all();
        @(negedge CLK);
        RST = 1'b1;

        // Single byte, TX raises busy two cycles after the launch pulse.
        idle(3);
        out_log.delete();
        tx_rise = 2; tx_len = 4;
        cycle(1'b1, 8'hA5, 1'b0);
        idle(15);
        check("a5_pulses", 32'(out_log.size()), 32'd1);
        if (out_log.size() > 0) check("a5_data", 32'(out_log[0]), 32'hA5);

        // Three back-to-back bytes, 11-cycle busy per frame.
        out_log.delete();
        tx_len = 11;
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        idle(60);
        check("b2b_pulses", 32'(out_log.size()), 32'd3);
        if (out_log.size() == 3) begin
            check("b2b_0", 32'(out_log[0]), 32'h11);
            check("b2b_1", 32'(out_log[1]), 32'h22);
            check("b2b_2", 32'(out_log[2]), 32'h33);
        end

        // Fill with TX stuck busy: 9th write dropped.
        do_reset();
        tx_manual = 1'b1; tx_manual_val = 1'b1;
        cycle(1'b1, 8'hE0, 1'b0);
        idle(3);
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0);
        check("full_after8", 32'(FULL), 32'd1);
        check("count_after8", 32'(COUNT), 32'(DEPTH));
        cycle(1'b1, 8'h09, 1'b0);
        check("count_after9", 32'(COUNT), 32'(DEPTH));
        check("ovf_after9", 32'(OVF), 32'(OVF_EN));
        cycle(1'b1, 8'h0A, 1'b1);
        check("ovf_set_wins", 32'(OVF), 32'(OVF_EN));
        cycle(1'b0, '0, 1'b1);
        check("ovf_cleared", 32'(OVF), 32'd0);

        // Full FIFO: write on the same edge as a pop is still dropped.
        tx_manual_val = 1'b0;
        cycle(1'b0, '0, 1'b0);
        cycle(1'b1, 8'h77, 1'b0);
        check("pop_drop_count", 32'(COUNT), 32'(DEPTH - 1));
        check("pop_drop_pdata", 32'(P_DATA), 32'h01);

        // Reset in WAIT_DONE with four entries queued.
        do_reset();
        tx_manual_val = 1'b1;
        cycle(1'b1, 8'hC0, 1'b0);
        idle(3);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'hC1 + 8'(i), 1'b0);
        #2 RST = 1'b0;
        #1;
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_dv", 32'(DATA_VALID), 32'd0);
        check("rst_pdata", 32'(P_DATA), 32'd0);
        check("rst_ovf", 32'(OVF), 32'd0);
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
        out_log.delete();
        idle(3);
        tx_manual_val = 1'b0;
        idle(4);
        check("rst_no_launch", 32'(out_log.size()), 32'd0);
        tx_manual = 1'b0;

        // Randomized traffic.
        tx_rand = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 3));
        end
        tx_rand = 1'b0;

        // 20 bytes across pointer wrap, never overfilled.
        tx_manual = 1'b1; tx_manual_val = 1'b0;
        idle(40);
        tx_manual = 1'b0;
        do_reset();
        out_log.delete();
        tx_rise = 1; tx_len = 3;
        begin
            int next = 0;
            for (int k = 0; k < 800 && out_log.size() < 20; k++) begin
                if (next < 20 && q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                    cycle(1'b1, 8'(next), 1'b0);
                    next++;
                end else begin
                    cycle(1'b0, '0, 1'b0);
                end
            end
        end
        check("wrap_count", 32'(out_log.size()), 32'd20);
        for (int i = 0; i < out_log.size() && i < 20; i++) check("wrap_byte", 32'(out_log[i]), 32'(i));
        check("wrap_ovf", 32'(OVF), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
